netbus_rr_arbiter: RTL and testbench
====================================

// Module: netbus_rr_arbiter
// PURPOSE
//  Frame-aware round-robin arbiter merging NUM_PORTS NetBus receive streams into one output.
//  All streams are already in the RCLK domain, e.g. outputs of NetBusSliceRx channels.
//  Grants one port per frame, holds it until the end-of-frame beat (bit 0) is accepted,
//  then rotates priority. Replaces fixed-priority merging in NetBus Rx hubs with >2 ports.
// PARAMETERS
//  DATA_WIDTH     4  payload lanes; beat width W = DATA_WIDTH*9+14
//  NUM_PORTS      4  requester count, 2..16
//  REAL_TIME_MASK 0  bit i=1: port i eligible on S_VALID[i]; bit i=0: eligible only on S_FRAME[i]
// PORTS
//  RCLK     in   1            clock
//  RESETn   in   1            synchronous reset, active-low
//  S_DATA   in   NUM_PORTS*W  port i beat at [i*W +: W]
//  S_VALID  in   NUM_PORTS    per-port beat valid
//  S_FRAME  in   NUM_PORTS    per-port "complete frame buffered" flag
//  S_READY  out  NUM_PORTS    per-port ready
//  RDATA    out  W            merged beat; RDATA[0]=1 marks last beat of frame
//  RVALID   out  1            merged valid
//  RREADY   in   1            downstream ready
//  GRANT    out  NUM_PORTS    one-hot current owner, 0 when idle
//  BUSY     out  1            1 while a frame is in transfer
// BEHAVIOUR
//  - States: IDLE, XFER. Registers: state, grant index g, last-served pointer ptr.
//  - eligible[i] = REAL_TIME_MASK[i] ? S_VALID[i] : S_FRAME[i].
//  - IDLE: RVALID=0, all S_READY=0, RDATA=S_DATA of port 0 (don't-care).
//    If any eligible: g <= first eligible in search order ptr+1, ptr+2, ... wrapping mod NUM_PORTS.
//    Then state <= XFER. Otherwise remain IDLE.
//  - XFER (combinational mux): RDATA=S_DATA[g], RVALID=S_VALID[g], S_READY[g]=RREADY;
//    all other S_READY=0. GRANT=1<<g, BUSY=1.
//  - Beat accepted when RVALID&RREADY. Accepted beat with RDATA[0]=1:
//    ptr <= g, state <= IDLE next cycle.
//  - Latency: eligible sampled in cycle t -> grant and first beat possible in cycle t+1.
//    One idle cycle always separates consecutive frames.
//  - Grant is never revoked mid-frame; RVALID low gaps inside a frame hold the grant.
//  - An eligible port drop in IDLE is not held; only the current-cycle eligible set counts.
//  - Single-beat frame (first beat has bit 0 set): XFER lasts exactly one accepting cycle.
//  - Fairness: port just served has lowest priority next round. Any continuously
//    eligible port is granted within NUM_PORTS-1 frames.
//  - Reset (RESETn=0 at RCLK edge, also mid-frame):
//    state=IDLE, g=0, ptr=NUM_PORTS-1 (port 0 wins first), GRANT=0, BUSY=0,
//    RVALID=0, S_READY=0.
//    The partially sent frame is truncated; recovery is the sink's responsibility.
//  - No arithmetic beyond modulo-NUM_PORTS index wrap; ptr width clog2(NUM_PORTS).
// CONFIGURATION
//  NETBUS_ARB_STATS_EN defined: adds output FRAME_CNT [NUM_PORTS*16-1:0].
//    Port i count at [i*16 +: 16]; +1 on each accepted last beat from port i.
//    Wraps 0xFFFF->0; reset to 0 by RESETn.
//  NETBUS_ARB_STATS_EN undefined: FRAME_CNT port and counters absent; behaviour otherwise identical.
// TESTING
//  T1 reset: RESETn=0 for 2 cycles, all S_FRAME=1 -> GRANT=0, RVALID=0.
//     Cycle after release: GRANT=4'b0001.
//  T2 round-robin: all 4 ports S_FRAME=1, 3-beat frames, RREADY=1.
//     -> grant order 0,1,2,3,0; one idle cycle between frames; 4 cycles per frame.
//  T3 backpressure: RREADY toggles 1010 mid-frame of port 2.
//     -> GRANT stays 4'b0100; S_READY[2]==RREADY; no beat duplicated or lost.
//  T4 real-time: REAL_TIME_MASK=4'b0010, only S_VALID[1]=1, S_FRAME=0.
//     -> port 1 granted; port 3 with S_VALID only is never granted.
//  T5 reset mid-frame: assert RESETn=0 after beat 2 of 5 from port 1.
//     -> next cycle GRANT=0, S_READY=0; after release port 0 is searched first.
//  T6 stats (NETBUS_ARB_STATS_EN): 3 frames from port 3 -> FRAME_CNT[63:48]=3.
//     Preload 0xFFFF via 65535 frames, one more frame -> 0.

Source files
------------

// File: rtl/netbus_rr_arbiter.sv
// Frame-aware round-robin merge of NUM_PORTS NetBus Rx streams into one output.
// Ports: RCLK, RESETn (sync, active-low); S_DATA/S_VALID/S_FRAME in, S_READY out;
//   RDATA/RVALID out, RREADY in; GRANT one-hot owner, BUSY while a frame moves.
// Option: define NETBUS_ARB_STATS_EN to add FRAME_CNT (16-bit frames per port).
module netbus_rr_arbiter #(
  parameter int                   DATA_WIDTH     = 4,
  parameter int                   NUM_PORTS      = 4,
  parameter logic [NUM_PORTS-1:0] REAL_TIME_MASK = '0,
  localparam int                  W              = DATA_WIDTH*9+14
) (
  input  logic                   RCLK,
  input  logic                   RESETn,
  input  logic [NUM_PORTS*W-1:0] S_DATA,
  input  logic [NUM_PORTS-1:0]   S_VALID,
  input  logic [NUM_PORTS-1:0]   S_FRAME,
  output logic [NUM_PORTS-1:0]   S_READY,
  output logic [W-1:0]           RDATA,
  output logic                   RVALID,
  input  logic                   RREADY,
  output logic [NUM_PORTS-1:0]   GRANT,
  output logic                   BUSY
`ifdef NETBUS_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*16-1:0] FRAME_CNT
`endif
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int SW = PW + 1;

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   g, g_nx;
  logic [PW-1:0]   ptr, ptr_nx;
  logic [NUM_PORTS-1:0] elig;
  logic [PW-1:0]   pick;
  logic            found;
  logic [SW-1:0]   idx;
  logic            last_acc;

  assign elig = (REAL_TIME_MASK & S_VALID) | (~REAL_TIME_MASK & S_FRAME);

  // Walk ptr+NUM_PORTS down to ptr+1 so the nearest eligible port wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = {1'b0, ptr} + SW'(k);
      if (idx >= SW'(NUM_PORTS))
        idx = idx - SW'(NUM_PORTS);
      if (elig[idx[PW-1:0]]) begin
        pick  = idx[PW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    RDATA    = S_DATA[0 +: W];
    RVALID   = 1'b0;
    S_READY  = '0;
    GRANT    = '0;
    BUSY     = 1'b0;
    state_nx = state;
    g_nx     = g;
    ptr_nx   = ptr;
    unique case (state)
      IDLE: begin
        if (found) begin
          g_nx     = pick;
          state_nx = XFER;
        end
      end
      XFER: begin
        RDATA      = S_DATA[g*W +: W];
        RVALID     = S_VALID[g];
        S_READY[g] = RREADY;
        GRANT      = NUM_PORTS'(1) << g;
        BUSY       = 1'b1;
        if (RVALID && RREADY && RDATA[0]) begin
          ptr_nx   = g;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign last_acc = BUSY & RVALID & RREADY & RDATA[0];

  always_ff @(posedge RCLK) begin
    if (!RESETn) begin
      state <= IDLE;
      g     <= '0;
      ptr   <= PW'(NUM_PORTS-1);
    end else begin
      state <= state_nx;
      g     <= g_nx;
      ptr   <= ptr_nx;
    end
  end

`ifdef NETBUS_ARB_STATS_EN
  logic [15:0] cnt [NUM_PORTS];

  always_ff @(posedge RCLK) begin
    if (!RESETn) begin
      for (int i = 0; i < NUM_PORTS; i++)
        cnt[i] <= '0;
    end else if (last_acc) begin
      cnt[g] <= cnt[g] + 16'd1;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    assign FRAME_CNT[i*16 +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_netbus_rr_arbiter.sv
// Bench for netbus_rr_arbiter: table of per-cycle vectors plus fairness/stats runs.
// Two instances: default mask, and REAL_TIME_MASK=4'b0010 for the real-time case.
module tb_netbus_rr_arbiter;

  localparam int DW = 4;
  localparam int NP = 4;
  localparam int W  = DW*9+14;

  logic            RCLK = 1'b0;
  logic            RESETn = 1'b0;
  logic [NP*W-1:0] S_DATA = '0;
  logic [NP-1:0]   S_VALID = '0;
  logic [NP-1:0]   S_FRAME = '0;
  logic            RREADY = 1'b0;

  logic [NP-1:0]   S_READY, GRANT, S_READY_rt, GRANT_rt;
  logic [W-1:0]    RDATA, RDATA_rt;
  logic            RVALID, BUSY, RVALID_rt, BUSY_rt;
`ifdef NETBUS_ARB_STATS_EN
  logic [NP*16-1:0] FRAME_CNT, FRAME_CNT_rt;
`endif

  always #5 RCLK = ~RCLK;

  netbus_rr_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) u_dut (
    .RCLK(RCLK), .RESETn(RESETn), .S_DATA(S_DATA), .S_VALID(S_VALID),
    .S_FRAME(S_FRAME), .S_READY(S_READY), .RDATA(RDATA), .RVALID(RVALID),
    .RREADY(RREADY), .GRANT(GRANT), .BUSY(BUSY)
`ifdef NETBUS_ARB_STATS_EN
    , .FRAME_CNT(FRAME_CNT)
`endif
  );

  netbus_rr_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP),
                      .REAL_TIME_MASK(4'b0010)) u_rt (
    .RCLK(RCLK), .RESETn(RESETn), .S_DATA(S_DATA), .S_VALID(S_VALID),
    .S_FRAME(S_FRAME), .S_READY(S_READY_rt), .RDATA(RDATA_rt),
    .RVALID(RVALID_rt), .RREADY(RREADY), .GRANT(GRANT_rt), .BUSY(BUSY_rt)
`ifdef NETBUS_ARB_STATS_EN
    , .FRAME_CNT(FRAME_CNT_rt)
`endif
  );

  typedef struct {
    logic       rstn;
    logic       chk;
    logic [3:0] fr;
    logic [3:0] va;
    logic       rr;
    logic       rt;
    int         len;
    logic [3:0] g;
    logic       rv;
  } vec_t;

  vec_t tbl[$];
  int   seg_len;
  logic seg_rt;
  int   beat [NP];
  int   out_beat;
  int   cur_len;
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic void push(logic rstn, logic chk, logic [3:0] fr,
                               logic [3:0] va, logic rr, logic [3:0] g,
                               logic rv);
    vec_t v;
    v.rstn = rstn; v.chk = chk; v.fr = fr; v.va = va; v.rr = rr;
    v.rt = seg_rt; v.len = seg_len; v.g = g; v.rv = rv;
    tbl.push_back(v);
  endfunction

  function automatic void seg(logic [3:0] fr, logic [3:0] va, int len,
                              logic rt);
    seg_len = len;
    seg_rt  = rt;
    push(1'b0, 1'b0, fr, va, 1'b1, 4'b0, 1'b0);
    push(1'b0, 1'b1, fr, va, 1'b1, 4'b0, 1'b0);
  endfunction

  function automatic void x(logic [3:0] fr, logic [3:0] va, logic rr,
                            logic [3:0] g, logic rv);
    push(1'b1, 1'b1, fr, va, rr, g, rv);
  endfunction

  task automatic drive_data();
    logic [W-1:0] w;
    for (int i = 0; i < NP; i++) begin
      w       = '0;
      w[15:8] = 8'(i);
      w[7:1]  = 7'(beat[i]);
      w[0]    = (beat[i] == cur_len-1);
      S_DATA[i*W +: W] = w;
    end
  endtask

  task automatic score(input logic [3:0] gs, input logic [W-1:0] rd);
    int idx;
    idx = 0;
    for (int i = 0; i < NP; i++)
      if (gs[i]) idx = i;
    check("rdata_port", rd[15:8], idx);
    check("rdata_beat", rd[7:1], out_beat);
    check("rdata_last", rd[0], out_beat == cur_len-1);
    out_beat = rd[0] ? 0 : out_beat + 1;
  endtask

  task automatic clear_src();
    for (int i = 0; i < NP; i++) beat[i] = 0;
    out_beat = 0;
  endtask

  int ord [5] = '{0, 1, 2, 3, 0};

  initial begin
    vec_t       v;
    logic [3:0] gs, rdys, acc;
    logic       rvs;
    logic [W-1:0] rds;
    int         first;
    logic       seen;

    clear_src();

    seg(4'hF, 4'hF, 3, 1'b0);
    x(4'hF, 4'hF, 1'b1, 4'b0, 1'b0);
    for (int f = 0; f < 5; f++) begin
      for (int b = 0; b < 3; b++)
        x(4'hF, 4'hF, 1'b1, 4'(1 << ord[f]), 1'b1);
      x(4'hF, 4'hF, 1'b1, 4'b0, 1'b0);
    end

    seg(4'b0100, 4'b0100, 3, 1'b0);
    x(4'b0100, 4'b0100, 1'b1, 4'b0000, 1'b0);
    x(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1);
    x(4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1);
    x(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1);
    x(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0);
    x(4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1);
    x(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1);
    x(4'b0100, 4'b0100, 1'b1, 4'b0000, 1'b0);
    x(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1);

    seg(4'b0000, 4'b1010, 3, 1'b1);
    x(4'b0000, 4'b1010, 1'b1, 4'b0000, 1'b0);
    for (int b = 0; b < 3; b++)
      x(4'b0000, 4'b1010, 1'b1, 4'b0010, 1'b1);
    x(4'b0000, 4'b1010, 1'b1, 4'b0000, 1'b0);
    x(4'b0000, 4'b1010, 1'b1, 4'b0010, 1'b1);

    seg(4'b0010, 4'b0010, 5, 1'b0);
    x(4'b0010, 4'b0010, 1'b1, 4'b0000, 1'b0);
    x(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1);
    x(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1);
    push(1'b0, 1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1);
    x(4'b0011, 4'b0011, 1'b1, 4'b0000, 1'b0);
    for (int b = 0; b < 5; b++)
      x(4'b0011, 4'b0011, 1'b1, 4'b0001, 1'b1);
    x(4'b0011, 4'b0011, 1'b1, 4'b0000, 1'b0);
    x(4'b0011, 4'b0011, 1'b1, 4'b0010, 1'b1);

    seg(4'b0101, 4'b0101, 1, 1'b0);
    x(4'b0101, 4'b0101, 1'b1, 4'b0000, 1'b0);
    x(4'b0101, 4'b0101, 1'b1, 4'b0001, 1'b1);
    x(4'b0101, 4'b0101, 1'b1, 4'b0000, 1'b0);
    x(4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1);
    x(4'b0101, 4'b0101, 1'b1, 4'b0000, 1'b0);
    x(4'b0101, 4'b0101, 1'b1, 4'b0001, 1'b1);

    seg(4'b0001, 4'b0001, 1, 1'b0);
    x(4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0);
    x(4'b0100, 4'b0101, 1'b1, 4'b0001, 1'b1);
    x(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);
    x(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0);

    foreach (tbl[r]) begin
      v       = tbl[r];
      RESETn  = v.rstn;
      S_FRAME = v.fr;
      S_VALID = v.va;
      RREADY  = v.rr;
      cur_len = v.len;
      drive_data();
      @(negedge RCLK);
      gs   = v.rt ? GRANT_rt   : GRANT;
      rdys = v.rt ? S_READY_rt : S_READY;
      rvs  = v.rt ? RVALID_rt  : RVALID;
      rds  = v.rt ? RDATA_rt   : RDATA;
      if (v.chk) begin
        check($sformatf("grant[%0d]", r), gs, v.g);
        check($sformatf("rvalid[%0d]", r), rvs, v.rv);
        check($sformatf("s_ready[%0d]", r), rdys, v.rr ? v.g : 4'b0);
        check($sformatf("busy[%0d]", r),
              v.rt ? BUSY_rt : BUSY, |v.g);
        if (v.rt)
          check($sformatf("main_idle[%0d]", r), GRANT, 4'b0);
      end
      if (v.rstn && rvs && RREADY)
        score(gs, rds);
      acc = S_VALID & rdys;
      @(posedge RCLK);
      #1;
      if (!v.rstn) begin
        clear_src();
      end else begin
        for (int i = 0; i < NP; i++)
          if (acc[i])
            beat[i] = (beat[i] == cur_len-1) ? 0 : beat[i] + 1;
      end
    end

    clear_src();
    RESETn  = 1'b0;
    S_FRAME = 4'hF;
    S_VALID = 4'hF;
    RREADY  = 1'b1;
    cur_len = 1;
    drive_data();
    repeat (2) @(posedge RCLK);
    #1;
    RESETn = 1'b1;
    first  = 99;
    seen   = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge RCLK);
      if (!seen && GRANT[3]) begin
        first = n;
        seen  = 1'b1;
      end
    end
    check("fair_port3_cycle", first, 7);

`ifdef NETBUS_ARB_STATS_EN
    RESETn  = 1'b0;
    S_FRAME = 4'b1000;
    S_VALID = 4'b1000;
    repeat (2) @(posedge RCLK);
    #1;
    RESETn = 1'b1;
    repeat (7) @(negedge RCLK);
    check("frame_cnt_p3", FRAME_CNT[63:48], 16'd3);
    check("frame_cnt_p0", FRAME_CNT[15:0], 16'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
